// File: rtl/bus_arbiter_rr.sv
// Three-port round-robin arbiter that shares the system bus between the CPU
// instruction port (A, read-only), the CPU data port (B) and the DMA port (C).
// Every bus transaction is registered. A watchdog aborts slave accesses that
// never return ready.
module bus_arbiter_rr #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  // system bus
  output logic        o_bus_rw,
  output logic        o_bus_request,
  input  logic        i_bus_ready,
  output logic [31:0] o_bus_address,
  input  logic [31:0] i_bus_rdata,
  output logic [31:0] o_bus_wdata,
  // port A (instruction fetch, read-only)
  input  logic        i_pa_request,
  output logic        o_pa_ready,
  input  logic [31:0] i_pa_address,
  output logic [31:0] o_pa_rdata,
  output logic        o_pa_busy,
  // port B (CPU data)
  input  logic        i_pb_rw,
  input  logic        i_pb_request,
  input  logic [31:0] i_pb_address,
  input  logic [31:0] i_pb_wdata,
  output logic        o_pb_ready,
  output logic [31:0] o_pb_rdata,
  output logic        o_pb_busy,
  // port C (DMA)
  input  logic        i_pc_rw,
  input  logic        i_pc_request,
  input  logic [31:0] i_pc_address,
  input  logic [31:0] i_pc_wdata,
  output logic        o_pc_ready,
  output logic [31:0] o_pc_rdata,
  output logic        o_pc_busy,
  // watchdog
  output logic        o_fault,
  output logic [31:0] o_fault_address
);

  localparam int unsigned NP = 3;
  localparam int unsigned DW = 32;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam bit               TO_EN   = (TIMEOUT != 0);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESPOND} state_t;

  state_t          state_q, state_d;
  logic [NP-1:0]   last_grant_q, last_grant_d;
  logic [NP-1:0]   grant_q, grant_d;
  logic            mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            bus_req_q, bus_req_d;
  logic            bus_rw_q, bus_rw_d;
  logic [DW-1:0]   bus_addr_q, bus_addr_d;
  logic [DW-1:0]   bus_wdata_q, bus_wdata_d;
  logic [NP-1:0]   ready_q, ready_d;
  logic [DW-1:0]   pa_rdata_q, pa_rdata_d;
  logic [DW-1:0]   pb_rdata_q, pb_rdata_d;
  logic [DW-1:0]   pc_rdata_q, pc_rdata_d;
  logic            fault_q, fault_d;
  logic [DW-1:0]   fault_addr_q, fault_addr_d;

  logic [NP-1:0]   elig_c;
  logic [NP-1:0]   pick_c;
  logic            timeout_hit_c;
  logic [DW-1:0]   rsp_data_c;

  // Eligible requesters (port served in the previous RESPOND is masked) and rotating-priority pick
  always_comb begin
    elig_c = {i_pc_request, i_pb_request, i_pa_request} & ~(mask_q ? last_grant_q : '0);
    pick_c = '0;
    unique case (last_grant_q)
      3'b001: begin
        if (elig_c[1])      pick_c = 3'b010;
        else if (elig_c[2]) pick_c = 3'b100;
        else if (elig_c[0]) pick_c = 3'b001;
      end
      3'b010: begin
        if (elig_c[2])      pick_c = 3'b100;
        else if (elig_c[0]) pick_c = 3'b001;
        else if (elig_c[1]) pick_c = 3'b010;
      end
      default: begin
        if (elig_c[0])      pick_c = 3'b001;
        else if (elig_c[1]) pick_c = 3'b010;
        else if (elig_c[2]) pick_c = 3'b100;
      end
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    mask_d       = 1'b0;
    cnt_d        = cnt_q;
    bus_req_d    = bus_req_q;
    bus_rw_d     = bus_rw_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    ready_d      = '0;
    pa_rdata_d   = pa_rdata_q;
    pb_rdata_d   = pb_rdata_q;
    pc_rdata_d   = pc_rdata_q;
    fault_d      = 1'b0;
    fault_addr_d = fault_addr_q;
    timeout_hit_c = TO_EN && (cnt_q == TO_LAST);
    rsp_data_c    = i_bus_ready ? i_bus_rdata : '0;

    unique case (state_q)
      S_IDLE: begin
        if (|pick_c) begin
          grant_d      = pick_c;
          last_grant_d = pick_c;
          bus_req_d    = 1'b1;
          cnt_d        = '0;
          state_d      = S_ISSUE;
          if (pick_c[0]) begin
            bus_addr_d  = i_pa_address;
            bus_rw_d    = 1'b0;
            bus_wdata_d = '0;
          end else if (pick_c[1]) begin
            bus_addr_d  = i_pb_address;
            bus_rw_d    = i_pb_rw;
            bus_wdata_d = i_pb_wdata;
          end else begin
            bus_addr_d  = i_pc_address;
            bus_rw_d    = i_pc_rw;
            bus_wdata_d = i_pc_wdata;
          end
        end
      end
      S_ISSUE: begin
        // ready has priority over a coincident watchdog expiry
        if (i_bus_ready || timeout_hit_c) begin
          bus_req_d = 1'b0;
          ready_d   = grant_q;
          state_d   = S_RESPOND;
          if (grant_q[0]) pa_rdata_d = rsp_data_c;
          if (grant_q[1]) pb_rdata_d = rsp_data_c;
          if (grant_q[2]) pc_rdata_d = rsp_data_c;
          if (!i_bus_ready) begin
            fault_d      = 1'b1;
            fault_addr_d = bus_addr_q;
          end
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESPOND: begin
        grant_d = '0;
        mask_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 3'b100;
      grant_q      <= '0;
      mask_q       <= 1'b0;
      cnt_q        <= '0;
      bus_req_q    <= 1'b0;
      bus_rw_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      ready_q      <= '0;
      pa_rdata_q   <= '0;
      pb_rdata_q   <= '0;
      pc_rdata_q   <= '0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      mask_q       <= mask_d;
      cnt_q        <= cnt_d;
      bus_req_q    <= bus_req_d;
      bus_rw_q     <= bus_rw_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      ready_q      <= ready_d;
      pa_rdata_q   <= pa_rdata_d;
      pb_rdata_q   <= pb_rdata_d;
      pc_rdata_q   <= pc_rdata_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign o_bus_request   = bus_req_q;
  assign o_bus_rw        = bus_rw_q;
  assign o_bus_address   = bus_addr_q;
  assign o_bus_wdata     = bus_wdata_q;
  assign o_pa_ready      = ready_q[0];
  assign o_pb_ready      = ready_q[1];
  assign o_pc_ready      = ready_q[2];
  assign o_pa_busy       = grant_q[0];
  assign o_pb_busy       = grant_q[1];
  assign o_pc_busy       = grant_q[2];
  assign o_pa_rdata      = pa_rdata_q;
  assign o_pb_rdata      = pb_rdata_q;
  assign o_pc_rdata      = pc_rdata_q;
  assign o_fault         = fault_q;
  assign o_fault_address = fault_addr_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Scoreboard bench for bus_arbiter_rr: stimulus pushes expected bus and port
// responses; monitors pop and compare when the DUT presents them.
module tb_bus_arbiter_rr;

  logic        i_clock;
  logic        i_reset_n;
  logic        o_bus_rw, o_bus_request, i_bus_ready;
  logic [31:0] o_bus_address, i_bus_rdata, o_bus_wdata;
  logic        i_pa_request, o_pa_ready, o_pa_busy;
  logic [31:0] i_pa_address, o_pa_rdata;
  logic        i_pb_rw, i_pb_request, o_pb_ready, o_pb_busy;
  logic [31:0] i_pb_address, i_pb_wdata, o_pb_rdata;
  logic        i_pc_rw, i_pc_request, o_pc_ready, o_pc_busy;
  logic [31:0] i_pc_address, i_pc_wdata, o_pc_rdata;
  logic        o_fault;
  logic [31:0] o_fault_address;

  bus_arbiter_rr #(.TIMEOUT(16), .CNT_W(8)) dut (
    .i_clock(i_clock), .i_reset_n(i_reset_n),
    .o_bus_rw(o_bus_rw), .o_bus_request(o_bus_request), .i_bus_ready(i_bus_ready),
    .o_bus_address(o_bus_address), .i_bus_rdata(i_bus_rdata), .o_bus_wdata(o_bus_wdata),
    .i_pa_request(i_pa_request), .o_pa_ready(o_pa_ready), .i_pa_address(i_pa_address),
    .o_pa_rdata(o_pa_rdata), .o_pa_busy(o_pa_busy),
    .i_pb_rw(i_pb_rw), .i_pb_request(i_pb_request), .i_pb_address(i_pb_address),
    .i_pb_wdata(i_pb_wdata), .o_pb_ready(o_pb_ready), .o_pb_rdata(o_pb_rdata), .o_pb_busy(o_pb_busy),
    .i_pc_rw(i_pc_rw), .i_pc_request(i_pc_request), .i_pc_address(i_pc_address),
    .i_pc_wdata(i_pc_wdata), .o_pc_ready(o_pc_ready), .o_pc_rdata(o_pc_rdata), .o_pc_busy(o_pc_busy),
    .o_fault(o_fault), .o_fault_address(o_fault_address)
  );

  typedef struct {
    int          port;
    logic [31:0] rdata;
    bit          fault;
    logic [31:0] faddr;
    int          gap;
  } rsp_t;

  typedef struct {
    int          port;
    bit          rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          len;
  } bus_t;

  rsp_t exp_rsp[$];
  bus_t exp_bus[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   slave_lat = 1;

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;
  always @(posedge i_clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_bus(input int p, input bit rw, input logic [31:0] a, input logic [31:0] wd, input int len);
    bus_t b;
    b.port = p; b.rw = rw; b.addr = a; b.wdata = wd; b.len = len;
    exp_bus.push_back(b);
  endtask

  task automatic push_rsp(input int p, input logic [31:0] rd, input bit f, input logic [31:0] fa, input int gap);
    rsp_t r;
    r.port = p; r.rdata = rd; r.fault = f; r.faddr = fa; r.gap = gap;
    exp_rsp.push_back(r);
  endtask

  function automatic logic [31:0] sdata(input logic [31:0] a);
    return (a == 32'h0000_0100) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_5A5A);
  endfunction

  function automatic logic port_ready(input int p);
    return (p == 0) ? o_pa_ready : (p == 1) ? o_pb_ready : o_pc_ready;
  endfunction

  // Slave model: raises ready for one cycle after slave_lat request cycles (0 = never)
  initial begin
    int scnt;
    scnt = 0;
    i_bus_ready = 1'b0;
    i_bus_rdata = '0;
    forever begin
      @(negedge i_clock);
      if (i_bus_ready) begin
        i_bus_ready = 1'b0;
        scnt = 0;
      end else if (o_bus_request) begin
        scnt++;
        if (slave_lat != 0 && scnt == slave_lat) begin
          i_bus_ready = 1'b1;
          i_bus_rdata = sdata(o_bus_address);
        end
      end else begin
        scnt = 0;
      end
    end
  end

  // Bus monitor: checks each issued transaction and its request length
  initial begin
    bit   prev;
    int   len, exp_len;
    bus_t b;
    prev = 1'b0; len = 0; exp_len = 0;
    forever begin
      @(negedge i_clock);
      if (o_bus_request && !prev) begin
        if (exp_bus.size() == 0) begin
          chk("bus_unexpected_request", 32'd1, 32'd0);
          exp_len = 0;
        end else begin
          b = exp_bus.pop_front();
          chk("bus_addr", o_bus_address, b.addr);
          chk("bus_rw", 32'(o_bus_rw), 32'(b.rw));
          chk("bus_wdata", o_bus_wdata, b.wdata);
          chk("bus_busy", 32'({o_pc_busy, o_pb_busy, o_pa_busy}), 32'(1 << b.port));
          exp_len = b.len;
        end
        len = 1;
      end else if (o_bus_request) begin
        len++;
      end else if (prev && exp_len != 0) begin
        chk("bus_req_cycles", 32'(len), 32'(exp_len));
      end
      prev = o_bus_request;
    end
  end

  // Response monitor: checks each port ready pulse, its data and the fault flag
  initial begin
    int   last_cyc;
    rsp_t r;
    logic [31:0] act_rd;
    int   act_p;
    last_cyc = 0;
    forever begin
      @(negedge i_clock);
      if (o_pa_ready || o_pb_ready || o_pc_ready) begin
        if ($countones({o_pc_ready, o_pb_ready, o_pa_ready}) != 1)
          chk("multi_ready", 32'({o_pc_ready, o_pb_ready, o_pa_ready}), 32'd0);
        act_p  = o_pa_ready ? 0 : o_pb_ready ? 1 : 2;
        act_rd = o_pa_ready ? o_pa_rdata : o_pb_ready ? o_pb_rdata : o_pc_rdata;
        if (exp_rsp.size() == 0) begin
          chk("unexpected_ready", 32'(act_p), 32'hFFFF_FFFF);
        end else begin
          r = exp_rsp.pop_front();
          chk("ready_port", 32'(act_p), 32'(r.port));
          chk("ready_rdata", act_rd, r.rdata);
          chk("fault_flag", 32'(o_fault), 32'(r.fault));
          if (r.fault) chk("fault_addr", o_fault_address, r.faddr);
          if (r.gap >= 0) chk("ready_gap", 32'(cyc - last_cyc), 32'(r.gap));
        end
        last_cyc = cyc;
      end else if (o_fault) begin
        chk("fault_without_ready", 32'd1, 32'd0);
      end
    end
  end

  task automatic set_req(input int p, input bit req, input bit rw, input logic [31:0] a, input logic [31:0] wd);
    case (p)
      0: begin i_pa_request = req; i_pa_address = a; end
      1: begin i_pb_request = req; i_pb_rw = rw; i_pb_address = a; i_pb_wdata = wd; end
      default: begin i_pc_request = req; i_pc_rw = rw; i_pc_address = a; i_pc_wdata = wd; end
    endcase
  endtask

  // Master: hold request until ready is seen, then release
  task automatic master(input int p, input bit rw, input logic [31:0] a, input logic [31:0] wd);
    int n;
    @(negedge i_clock);
    set_req(p, 1'b1, rw, a, wd);
    n = 0;
    do begin
      @(negedge i_clock);
      n++;
    end while (!port_ready(p) && n < 200);
    chk("master_wait_done", 32'(port_ready(p)), 32'd1);
    set_req(p, 1'b0, rw, a, wd);
  endtask

  task automatic do_reset();
    @(negedge i_clock);
    #2 i_reset_n = 1'b0;
    #1;
    chk("rst_bus_request", 32'(o_bus_request), 32'd0);
    chk("rst_busy", 32'({o_pc_busy, o_pb_busy, o_pa_busy}), 32'd0);
    chk("rst_ready", 32'({o_pc_ready, o_pb_ready, o_pa_ready}), 32'd0);
    @(negedge i_clock);
    i_reset_n = 1'b1;
  endtask

  initial begin
    int n;
    i_reset_n = 1'b1;
    i_pa_request = 0; i_pa_address = '0;
    i_pb_request = 0; i_pb_rw = 0; i_pb_address = '0; i_pb_wdata = '0;
    i_pc_request = 0; i_pc_rw = 0; i_pc_address = '0; i_pc_wdata = '0;
    #3 i_reset_n = 1'b0;
    #1;
    chk("rst_bus_address", o_bus_address, 32'h0);
    chk("rst_bus_wdata", o_bus_wdata, 32'h0);
    chk("rst_bus_rw", 32'(o_bus_rw), 32'd0);
    chk("rst_fault", 32'(o_fault), 32'd0);
    chk("rst_fault_addr", o_fault_address, 32'h0);
    chk("rst_pa_rdata", o_pa_rdata, 32'h0);
    repeat (2) @(negedge i_clock);
    i_reset_n = 1'b1;

    // 1: single read on A, 2-cycle slave
    slave_lat = 2;
    push_bus(0, 1'b0, 32'h0000_0100, 32'h0, 2);
    push_rsp(0, 32'hDEAD_BEEF, 1'b0, 32'h0, -1);
    master(0, 1'b0, 32'h0000_0100, 32'h0);
    repeat (2) @(negedge i_clock);

    // 2: write on B
    slave_lat = 1;
    push_bus(1, 1'b1, 32'h1000_0004, 32'hCAFE_F00D, 1);
    push_rsp(1, 32'h4A5A_5A5E, 1'b0, 32'h0, -1);
    master(1, 1'b1, 32'h1000_0004, 32'hCAFE_F00D);
    repeat (2) @(negedge i_clock);

    // 3: round-robin from reset, all three request together
    do_reset();
    push_bus(0, 1'b0, 32'h0000_0200, 32'h0, 1);
    push_bus(1, 1'b0, 32'h1000_0008, 32'h0, 1);
    push_bus(2, 1'b1, 32'h2000_0010, 32'h1122_3344, 1);
    push_rsp(0, 32'h5A5A_585A, 1'b0, 32'h0, -1);
    push_rsp(1, 32'h4A5A_5A52, 1'b0, 32'h0, 3);
    push_rsp(2, 32'h7A5A_5A4A, 1'b0, 32'h0, 3);
    fork
      master(0, 1'b0, 32'h0000_0200, 32'h0);
      master(1, 1'b0, 32'h1000_0008, 32'h0);
      master(2, 1'b1, 32'h2000_0010, 32'h1122_3344);
    join
    repeat (2) @(negedge i_clock);

    // 4: watchdog abort on C, then A completes normally
    slave_lat = 0;
    push_bus(2, 1'b0, 32'h3000_0000, 32'h0, 16);
    push_rsp(2, 32'h0, 1'b1, 32'h3000_0000, -1);
    master(2, 1'b0, 32'h3000_0000, 32'h0);
    slave_lat = 1;
    push_bus(0, 1'b0, 32'h0000_0100, 32'h0, 1);
    push_rsp(0, 32'hDEAD_BEEF, 1'b0, 32'h0, -1);
    master(0, 1'b0, 32'h0000_0100, 32'h0);
    chk("fault_addr_held", o_fault_address, 32'h3000_0000);
    repeat (2) @(negedge i_clock);

    // 5: ready lands on the timeout edge
    slave_lat = 16;
    push_bus(1, 1'b0, 32'h1000_0020, 32'h0, 16);
    push_rsp(1, 32'h4A5A_5A7A, 1'b0, 32'h0, -1);
    master(1, 1'b0, 32'h1000_0020, 32'h0);
    repeat (2) @(negedge i_clock);

    // 6: reset while B is in ISSUE, pending A granted first afterwards
    slave_lat = 0;
    push_bus(1, 1'b0, 32'h1000_0040, 32'h0, 0);
    @(negedge i_clock);
    set_req(1, 1'b1, 1'b0, 32'h1000_0040, 32'h0);
    n = 0;
    while (!o_bus_request && n < 20) begin @(negedge i_clock); n++; end
    chk("b_issue_seen", 32'(o_bus_request), 32'd1);
    repeat (3) @(negedge i_clock);
    #2 i_reset_n = 1'b0;
    #1;
    chk("midrst_bus_request", 32'(o_bus_request), 32'd0);
    chk("midrst_busy", 32'({o_pc_busy, o_pb_busy, o_pa_busy}), 32'd0);
    chk("midrst_ready", 32'({o_pc_ready, o_pb_ready, o_pa_ready}), 32'd0);
    set_req(1, 1'b0, 1'b0, 32'h1000_0040, 32'h0);
    set_req(0, 1'b1, 1'b0, 32'h0000_0400, 32'h0);
    slave_lat = 1;
    push_bus(0, 1'b0, 32'h0000_0400, 32'h0, 1);
    push_rsp(0, 32'h5A5A_5E5A, 1'b0, 32'h0, -1);
    repeat (2) @(negedge i_clock);
    i_reset_n = 1'b1;
    n = 0;
    do begin @(negedge i_clock); n++; end while (!o_pa_ready && n < 50);
    chk("a_after_reset_done", 32'(o_pa_ready), 32'd1);
    set_req(0, 1'b0, 1'b0, 32'h0000_0400, 32'h0);
    repeat (3) @(negedge i_clock);

    chk("bus_queue_empty", 32'(exp_bus.size()), 32'd0);
    chk("rsp_queue_empty", 32'(exp_rsp.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
